fp_div_seq: RTL

- Iterative IEEE-754 single-precision divider. It is the inverse-operation counterpart of the FP32 multiplier datapath.
- Subtracts the operand exponents and re-adds the bias.
- Divides the 24-bit significands with a restoring algorithm, one quotient bit per clock, then normalizes and packs the result.
- Sits beside the multiplier in the arithmetic unit, under a start/done handshake.

---
 rtl/fp_div_seq.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 single-precision divider.
// Restoring significand division, one quotient bit per clock, behind a
// start/done handshake. Denormal inputs are flushed to signed zero.
// Optional macro FP_DIV_ROUND_EN: one extra quotient bit plus sticky
// detection, giving round-to-nearest-even instead of truncation.
`timescale 1ns/1ps
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   Op_A,
    input  logic [EXP_W+MAN_W:0]   Op_B,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   Resultado,
    output logic                   div_by_zero,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);

    localparam int WIDTH = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;          // significand with hidden bit
    localparam int E_W   = EXP_W + 2;          // signed working exponent
`ifdef FP_DIV_ROUND_EN
    localparam int ITER  = SIG_W + 2;          // extra guard bit for rounding
`else
    localparam int ITER  = SIG_W + 1;
`endif
    localparam int CNT_W = $clog2(ITER);

    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
    localparam logic signed [E_W-1:0] BIAS_E    = E_W'(BIAS);
    localparam logic signed [E_W-1:0] EXP_MAX_E = $signed({2'b00, EXP_ONES});
    localparam logic signed [E_W-1:0] E_ONE     = E_W'(1);
    localparam logic signed [E_W-1:0] E_ZERO    = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic                    r_sign;
    logic signed [E_W-1:0]   r_exp;
    logic [SIG_W:0]          r_rem;            // partial remainder, 1 bit of headroom
    logic [SIG_W-1:0]        r_div;            // divisor significand
    logic [ITER-1:0]         r_quo;            // quotient bits, MSB first
    logic [CNT_W-1:0]        r_cnt;

    // ------------------------------------------------------------------
    // Operand decode (from the captured operands)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_sign;

    assign w_a_exp  = r_a[WIDTH-2 -: EXP_W];
    assign w_b_exp  = r_b[WIDTH-2 -: EXP_W];
    assign w_a_man  = r_a[MAN_W-1:0];
    assign w_b_man  = r_b[MAN_W-1:0];
    // A zero exponent field covers both true zero and denormals (flushed)
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_man == '0);
    assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_man == '0);
    assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_man != '0);
    assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_man != '0);
    assign w_sign   = r_a[WIDTH-1] ^ r_b[WIDTH-1];

    // Biased result exponent before normalization
    logic signed [E_W-1:0] w_exp_diff;
    assign w_exp_diff = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + BIAS_E;

    // ------------------------------------------------------------------
    // Special-case classification
    // ------------------------------------------------------------------
    logic             w_special;
    logic             w_spec_inv;
    logic             w_spec_dbz;
    logic [WIDTH-1:0] w_spec_res;

    // Resolve special operands in priority order; w_special=0 means divide
    always_comb begin
        w_special  = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_dbz = 1'b0;
        w_spec_res = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            w_spec_inv = 1'b1;
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_spec_dbz = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = {w_sign, {(WIDTH-1){1'b0}}};
        end else begin
            w_special  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step. In PREP the step works on the freshly
    // built significands, so the first quotient bit is produced while the
    // operands are classified; DIVIDE then supplies the remaining bits.
    // ------------------------------------------------------------------
    logic [SIG_W:0]   w_step_rem;
    logic [SIG_W-1:0] w_step_div;
    logic             w_step_ge;
    logic [SIG_W:0]   w_step_diff;
    logic [SIG_W:0]   w_step_next;

    assign w_step_rem  = (r_state == S_PREP) ? {1'b0, 1'b1, w_a_man} : r_rem;
    assign w_step_div  = (r_state == S_PREP) ? {1'b1, w_b_man} : r_div;
    assign w_step_ge   = (w_step_rem >= {1'b0, w_step_div});
    assign w_step_diff = w_step_ge ? (w_step_rem - {1'b0, w_step_div}) : w_step_rem;
    assign w_step_next = w_step_diff << 1;

    // ------------------------------------------------------------------
    // Normalization, optional rounding, range check and packing
    // ------------------------------------------------------------------
    logic                  w_norm_top;
    logic signed [E_W-1:0] w_exp_pre;
    logic signed [E_W-1:0] w_exp_fin;
    logic [MAN_W-1:0]      w_frac_fin;
    logic                  w_norm_ovf;
    logic                  w_norm_unf;
    logic [WIDTH-1:0]      w_norm_res;
`ifdef FP_DIV_ROUND_EN
    logic [MAN_W-1:0]      w_frac_raw;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_round_up;
    logic [MAN_W:0]        w_frac_sum;
`endif

    // Quotient lies in (0.5, 2): at most one left shift to normalize
    always_comb begin
        w_norm_top = r_quo[ITER-1];
        w_exp_pre  = w_norm_top ? r_exp : (r_exp - E_ONE);
`ifdef FP_DIV_ROUND_EN
        w_frac_raw = w_norm_top ? r_quo[ITER-2 -: MAN_W] : r_quo[ITER-3 -: MAN_W];
        w_guard    = w_norm_top ? r_quo[1] : r_quo[0];
        // When the quotient needs no shift, its last bit sits below the guard
        w_sticky   = (w_norm_top & r_quo[0]) | (r_rem != '0);
        w_round_up = w_guard & (w_sticky | w_frac_raw[0]);
        w_frac_sum = {1'b0, w_frac_raw} + {{MAN_W{1'b0}}, w_round_up};
        w_frac_fin = w_frac_sum[MAN_W-1:0];
        // Carry out of the fraction means the significand rounded up to 2.0
        w_exp_fin  = w_exp_pre + (w_frac_sum[MAN_W] ? E_ONE : E_ZERO);
`else
        w_frac_fin = w_norm_top ? r_quo[ITER-2 -: MAN_W] : r_quo[ITER-3 -: MAN_W];
        w_exp_fin  = w_exp_pre;
`endif
        w_norm_ovf = (w_exp_fin >= EXP_MAX_E);
        w_norm_unf = !w_norm_ovf && (w_exp_fin <= E_ZERO);
        if (w_norm_ovf) begin
            w_norm_res = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_norm_unf) begin
            w_norm_res = {r_sign, {(WIDTH-1){1'b0}}};
        end else begin
            w_norm_res = {r_sign, w_exp_fin[EXP_W-1:0], w_frac_fin};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Resultado   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a         <= Op_A;
                        r_b         <= Op_B;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        invalid     <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        Resultado   <= w_spec_res;
                        invalid     <= w_spec_inv;
                        div_by_zero <= w_spec_dbz;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_exp   <= w_exp_diff;
                        r_div   <= w_step_div;
                        r_rem   <= w_step_next;
                        r_quo   <= {{(ITER-1){1'b0}}, w_step_ge};
                        r_cnt   <= CNT_W'(ITER - 2);
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_step_next;
                    r_quo <= {r_quo[ITER-2:0], w_step_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    Resultado <= w_norm_res;
                    overflow  <= w_norm_ovf;
                    underflow <= w_norm_unf;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
